pe_core_sequencer: RTL and testbench
====================================

Name: pe_core_sequencer

Overview:
- Control sequencer directly upstream of the Eyeriss PE core.
- Accepts a start command plus an ifmap/filter load stream, then produces the per-cycle control the PE core consumes:
  - mode
  - map/filter/psum iterators
  - map_en, fil_en, regs_en, rst_accm, p_en_delay
  - mult_bits
- Runs load -> multiply passes -> pipeline drain -> psum readout, then pulses done.

Parameters:
- NMAP, 12: ifmap/filter entries per task, 1..12.
- NPSUM, 4: psum entries (passes) per task, 1..16.
- PIPE_LAT, 4: cycles from a regs_en cycle to its matching p_en_delay cycle, 1..8.

Ports:
- CLK  in  1  clock.
- clr_  in  1  reset, asynchronous, active-high.
- start  in  1  begin a task; sampled only in IDLE.
- shift_cfg  in  4  product shift; latched into mult_bits on accepted start.
- in_valid  in  1  load beat valid.
- in_ready  out  1  load beat accepted when in_valid & in_ready.
- mode  out  2  0 IDLE, 1 DATA, 2 MULT, 3 ACCU.
- map_en  out  1  write ifmap entry.
- fil_en  out  1  write filter entry.
- map_iterator  out  4  ifmap index.
- filter_iterator  out  4  filter index; always equals map_iterator.
- psum_iterator  out  4  psum index.
- regs_en  out  1  issue one product.
- rst_accm  out  1  0 = clear accumulator (first product of a pass), 1 = accumulate.
- p_en_delay  out  1  psum write enable.
- mult_bits  out  4  latched shift_cfg.
- out_valid  out  1  psum readout beat valid.
- out_idx  out  4  psum index of the readout beat.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at task end.

Behaviour:
- All outputs are registered.
- Reset: state is IDLE, every output is 0, all counters are 0, and the p_en shift register is cleared. Reset mid-task aborts the task immediately, with no done pulse.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> MULT after NMAP accepted beats.
  - MULT -> DRAIN after NPSUM*NMAP issue cycles.
  - DRAIN -> ACCU when the p_en shift register is empty.
  - ACCU -> DONE after NPSUM readout cycles.
  - DONE -> IDLE after 1 cycle.
- IDLE:
  - mode=0, in_ready=0.
  - start=1 latches shift_cfg into mult_bits and enters LOAD next cycle.
  - mult_bits holds its value until the next accepted start.
- LOAD:
  - mode=1, in_ready=1.
  - Each accepted beat: map_en=fil_en=1, map_iterator=filter_iterator=ld_cnt, then ld_cnt increments.
  - A cycle with in_valid=0 leaves all enables 0 and ld_cnt unchanged.
  - The NMAP-th accepted beat moves to MULT; in_ready drops in the same cycle the state changes.
- MULT:
  - mode=2, regs_en=1 every cycle.
  - Inner counter k runs 0..NMAP-1 and drives map_iterator and filter_iterator.
  - Outer counter p runs 0..NPSUM-1 and drives psum_iterator.
  - rst_accm=0 when k=0, otherwise 1.
  - k wraps to 0 with p incrementing; after the last k of p=NPSUM-1 the state moves to DRAIN.
- p_en_delay:
  - Output of a PIPE_LAT-deep shift register fed by regs_en.
  - It is 1 exactly PIPE_LAT cycles after each regs_en=1 cycle, regardless of state.
- DRAIN:
  - mode=2, regs_en=0, iterators hold their last values.
  - Leaves once the last p_en_delay pulse has been emitted.
- ACCU:
  - mode=3, psum_iterator steps 0..NPSUM-1, one entry per cycle.
  - out_valid=1 with out_idx equal to the previous cycle's psum_iterator, i.e. out_valid lags the step by 1 cycle.
- DONE:
  - done=1 for one cycle, mode=0.
  - This cycle also carries the final out_valid beat.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid outside LOAD is ignored.
  - NMAP=1: rst_accm=0 on every regs_en.
  - NPSUM=1: MULT lasts exactly NMAP cycles.
  - Iterators never exceed NMAP-1 or NPSUM-1.
- Width: counters are 4 bits. NMAP*NPSUM is counted with the nested k/p counters, with no separate product counter.
- Total task latency from start to done: 1 + NMAP (no stalls) + NMAP*NPSUM + PIPE_LAT + NPSUM + 1 cycles.

Decomposition:
- Shared package holds:
  - mode encodings IDLE=2'b00, DATA=2'b01, MULT=2'b10, ACCU=2'b11, shared with the PE core;
  - the state enum;
  - the default NMAP, NPSUM and PIPE_LAT values.
- One sub-module: pe_pen_delay_line, the PIPE_LAT shift register producing p_en_delay, which also provides an empty flag for DRAIN exit.

Test Plan:
- Nominal run, defaults, shift_cfg=4'd3, 12 beats with no stalls:
  - mode goes 1 for 12 cycles, 2 for 48+4 cycles, then 3 for 4 cycles.
  - mult_bits=3; done pulses at cycle 70 after start.
- Load stalls, in_valid toggling 1,0,1,0 during LOAD:
  - map_en pulses only on valid cycles; map_iterator goes 0,1,2,... with no skips; LOAD lasts 24 cycles.
- rst_accm/p_en alignment, NMAP=3, NPSUM=2, PIPE_LAT=4:
  - rst_accm pattern is 0,1,1,0,1,1.
  - p_en_delay is high for 6 cycles, starting exactly 4 cycles after the first regs_en.
- Readout: out_valid is high on 4 consecutive cycles with out_idx 0,1,2,3; the last beat coincides with done.
- Reset mid-MULT (clr_ pulsed at p=1, k=5):
  - all outputs 0 asynchronously, no done pulse.
  - A fresh start completes a full nominal run.
- Spurious inputs:
  - start asserted during MULT is ignored.
  - in_valid=1 during IDLE, MULT or ACCU produces no map_en or fil_en.

Source files
------------

// File: rtl/pe_core_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pe_core_sequencer_pkg
//   Constants shared between the PE core sequencer and the Eyeriss PE core:
//   - the mode encoding the PE core decodes;
//   - the sequencer state encoding;
//   - default task geometry and pipeline latency.
// ----------------------------------------------------------------------------
package pe_core_sequencer_pkg;

  // Default task geometry
  localparam int unsigned NmapDefault    = 12;  // ifmap/filter entries per task
  localparam int unsigned NpsumDefault   = 4;   // psum entries (passes) per task
  localparam int unsigned PipeLatDefault = 4;   // regs_en -> p_en_delay latency

  // PE core mode encoding
  typedef logic [1:0] mode_t;
  localparam mode_t ModeIdle = 2'b00;
  localparam mode_t ModeData = 2'b01;
  localparam mode_t ModeMult = 2'b10;
  localparam mode_t ModeAccu = 2'b11;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StLoad  = 3'd1;
  localparam state_t StMult  = 3'd2;
  localparam state_t StDrain = 3'd3;
  localparam state_t StAccu  = 3'd4;
  localparam state_t StDone  = 3'd5;

endpackage

// File: rtl/pe_pen_delay_line.sv
// ----------------------------------------------------------------------------
// pe_pen_delay_line
//   PIPE_LAT-deep shift register that turns each regs_en pulse into the
//   matching psum write enable PIPE_LAT cycles later.
//
// Ports
//   CLK        in   clock
//   clr_       in   asynchronous active-high reset, clears every stage
//   pulse_in   in   regs_en as seen by the PE core
//   pulse_out  out  p_en_delay, pulse_in delayed by PIPE_LAT cycles
//   empty      out  after the coming edge, no pulse is in flight except
//                   possibly the one then sitting in the output stage
// ----------------------------------------------------------------------------
module pe_pen_delay_line #(
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic CLK,
  input  logic clr_,
  input  logic pulse_in,
  output logic pulse_out,
  output logic empty
);

  logic [PIPE_LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = pulse_in;
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      sr_d[i] = sr_q[i-1];
    end
    // The sequencer state runs one cycle ahead of the registered PE controls,
    // so it may leave DRAIN while the final pulse is still reaching the output.
    empty = 1'b1;
    for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
      if (sr_d[i]) begin
        empty = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge clr_) begin
    if (clr_) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign pulse_out = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/pe_core_sequencer.sv
// ----------------------------------------------------------------------------
// pe_core_sequencer
//   Control sequencer in front of the Eyeriss PE core. After a start it
//   accepts NMAP ifmap/filter load beats, issues NPSUM passes of NMAP
//   products, waits for the multiplier pipeline to drain, reads the NPSUM
//   psums out and pulses done.
//
// Ports
//   CLK, clr_        clock, asynchronous active-high reset
//   start            begin a task (only looked at while idle)
//   shift_cfg[3:0]   product shift, captured into mult_bits on start
//   in_valid         load beat valid
//   in_ready         load beat accepted when in_valid & in_ready
//   mode[1:0]        PE core mode (idle/data/mult/accu)
//   map_en, fil_en   write ifmap / filter entry
//   map_iterator     ifmap index;  filter_iterator mirrors it
//   psum_iterator    psum index
//   regs_en          issue one product
//   rst_accm         0 clears the accumulator on the first product of a pass
//   p_en_delay       psum write enable, PIPE_LAT cycles after regs_en
//   mult_bits[3:0]   captured shift_cfg
//   out_valid/out_idx  psum readout beat, one cycle behind psum_iterator
//   busy, done       task in progress / one-cycle end-of-task pulse
//
// The FSM state register leads the PE-facing controls by one cycle: the
// controls are decoded from the current state and registered, so a beat
// accepted in cycle t is written (map_en) in cycle t+1. in_ready is decoded
// from the next state so it lines up with the state register.
// ----------------------------------------------------------------------------
module pe_core_sequencer
  import pe_core_sequencer_pkg::*;
#(
  parameter int unsigned NMAP     = NmapDefault,
  parameter int unsigned NPSUM    = NpsumDefault,
  parameter int unsigned PIPE_LAT = PipeLatDefault
) (
  input  logic       CLK,
  input  logic       clr_,
  input  logic       start,
  input  logic [3:0] shift_cfg,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] mode,
  output logic       map_en,
  output logic       fil_en,
  output logic [3:0] map_iterator,
  output logic [3:0] filter_iterator,
  output logic [3:0] psum_iterator,
  output logic       regs_en,
  output logic       rst_accm,
  output logic       p_en_delay,
  output logic [3:0] mult_bits,
  output logic       out_valid,
  output logic [3:0] out_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] MapLast  = 4'(NMAP - 1);
  localparam logic [3:0] PsumLast = 4'(NPSUM - 1);

  state_t     state_q, state_d;
  logic [3:0] ld_cnt_q, ld_cnt_d;
  logic [3:0] k_q, k_d;  // inner (map) counter
  logic [3:0] p_q, p_d;  // outer (psum) counter
  logic       accept;
  logic       pen_empty;

  // Decoded controls, registered into the output ports
  mode_t      mode_d;
  logic       map_en_d;
  logic [3:0] map_it_d;
  logic [3:0] psum_it_d;
  logic       regs_en_d;
  logic       rst_accm_d;
  logic       busy_d;
  logic       done_d;

  assign accept = in_valid & in_ready;

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    k_d      = k_q;
    p_d      = p_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoad;
          ld_cnt_d = '0;
          k_d      = '0;
          p_d      = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (ld_cnt_q == MapLast) begin
            state_d  = StMult;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + 4'd1;
          end
        end
      end
      StMult: begin
        if (k_q == MapLast) begin
          if (p_q == PsumLast) begin
            // k and p hold their last values through DRAIN
            state_d = StDrain;
          end else begin
            k_d = '0;
            p_d = p_q + 4'd1;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StDrain: begin
        if (pen_empty) begin
          state_d = StAccu;
          k_d     = '0;
          p_d     = '0;
        end
      end
      StAccu: begin
        if (p_q == PsumLast) begin
          state_d = StDone;
          p_d     = '0;
        end else begin
          p_d = p_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    mode_d     = ModeIdle;
    map_en_d   = 1'b0;
    map_it_d   = '0;
    psum_it_d  = '0;
    regs_en_d  = 1'b0;
    rst_accm_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_q != StIdle);
    case (state_q)
      StLoad: begin
        mode_d   = ModeData;
        map_en_d = accept;
        map_it_d = ld_cnt_q;
      end
      StMult: begin
        mode_d     = ModeMult;
        regs_en_d  = 1'b1;
        map_it_d   = k_q;
        psum_it_d  = p_q;
        rst_accm_d = (k_q != '0);
      end
      StDrain: begin
        mode_d     = ModeMult;
        map_it_d   = k_q;
        psum_it_d  = p_q;
        rst_accm_d = (k_q != '0);
      end
      StAccu: begin
        mode_d    = ModeAccu;
        psum_it_d = p_q;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge clr_) begin
    if (clr_) begin
      state_q  <= StIdle;
      ld_cnt_q <= '0;
      k_q      <= '0;
      p_q      <= '0;
      in_ready <= 1'b0;
      mult_bits <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      k_q      <= k_d;
      p_q      <= p_d;
      in_ready <= (state_d == StLoad);
      if ((state_q == StIdle) && start) begin
        mult_bits <= shift_cfg;
      end
    end
  end

  always_ff @(posedge CLK or posedge clr_) begin
    if (clr_) begin
      mode          <= ModeIdle;
      map_en        <= 1'b0;
      map_iterator  <= '0;
      psum_iterator <= '0;
      regs_en       <= 1'b0;
      rst_accm      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      out_idx       <= '0;
    end else begin
      mode          <= mode_d;
      map_en        <= map_en_d;
      map_iterator  <= map_it_d;
      psum_iterator <= psum_it_d;
      regs_en       <= regs_en_d;
      rst_accm      <= rst_accm_d;
      busy          <= busy_d;
      done          <= done_d;
      // Readout beat trails the psum step by one cycle
      out_valid     <= (mode == ModeAccu);
      out_idx       <= psum_iterator;
    end
  end

  assign fil_en          = map_en;
  assign filter_iterator = map_iterator;

  pe_pen_delay_line #(
    .PIPE_LAT(PIPE_LAT)
  ) u_pen_delay (
    .CLK      (CLK),
    .clr_     (clr_),
    .pulse_in (regs_en),
    .pulse_out(p_en_delay),
    .empty    (pen_empty)
  );

endmodule

// File: tb/tb_pe_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pe_core_sequencer
//   Drives whole tasks into pe_core_sequencer (default geometry) with random
//   load stalls, stray start/in_valid and random shift_cfg, and compares every
//   output cycle against a timeline derived from the task rules: load beats,
//   NMAP*NPSUM issue cycles, PIPE_LAT drain, NPSUM readout, done.
//   Cycle 0 of a task is the cycle in which start is held high.
// ----------------------------------------------------------------------------
module tb_pe_core_sequencer;

  localparam int NMAP     = 12;
  localparam int NPSUM    = 4;
  localparam int PIPE_LAT = 4;
  localparam int MaxCyc   = 256;

  logic       CLK, clr_, start, in_valid, in_ready;
  logic [3:0] shift_cfg;
  logic [1:0] mode;
  logic       map_en, fil_en, regs_en, rst_accm, p_en_delay, out_valid, busy, done;
  logic [3:0] map_iterator, filter_iterator, psum_iterator, mult_bits, out_idx;
  logic [30:0] all_outs;

  assign all_outs = {mode, map_en, fil_en, map_iterator, filter_iterator, psum_iterator,
                     regs_en, rst_accm, p_en_delay, mult_bits, out_valid, out_idx,
                     busy, done, in_ready};

  pe_core_sequencer #(
    .NMAP    (NMAP),
    .NPSUM   (NPSUM),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .CLK            (CLK),
    .clr_           (clr_),
    .start          (start),
    .shift_cfg      (shift_cfg),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mode           (mode),
    .map_en         (map_en),
    .fil_en         (fil_en),
    .map_iterator   (map_iterator),
    .filter_iterator(filter_iterator),
    .psum_iterator  (psum_iterator),
    .regs_en        (regs_en),
    .rst_accm       (rst_accm),
    .p_en_delay     (p_en_delay),
    .mult_bits      (mult_bits),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int         n_total, n_bad, cur_cyc;
  logic [3:0] prev_cfg;

  // Expected per-cycle trace of one task
  bit vld    [MaxCyc];
  bit e_rdy  [MaxCyc];
  bit e_men  [MaxCyc];
  bit e_reg  [MaxCyc];
  bit e_rac  [MaxCyc];
  bit e_pen  [MaxCyc];
  bit e_ov   [MaxCyc];
  bit e_busy [MaxCyc];
  bit e_done [MaxCyc];
  int e_mode [MaxCyc];
  int e_mit  [MaxCyc];
  int e_pit  [MaxCyc];
  int e_oidx [MaxCyc];

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cur_cyc, obs, exp);
    end
  endtask

  // kind 0: in_valid always high; 1: high on even cycles; 2: random stalls
  task automatic build_model(input int kind, output int d_cyc, output int r0);
    int beats, lend, nprod, a0, c;
    for (int i = 0; i < MaxCyc; i++) begin
      e_rdy[i] = 0; e_men[i] = 0; e_reg[i] = 0; e_rac[i] = 0; e_pen[i] = 0;
      e_ov[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_mode[i] = 0; e_mit[i] = 0; e_pit[i] = 0; e_oidx[i] = 0;
      case (kind)
        0:       vld[i] = 1;
        1:       vld[i] = (i % 2 == 0);
        default: vld[i] = (i > 60) ? 1'b1 : ($urandom_range(0, 9) < 7);
      endcase
    end
    beats = 0;
    lend  = 0;
    for (int i = 1; i < MaxCyc && beats < NMAP; i++) begin
      e_rdy[i] = 1;
      if (vld[i]) begin
        e_men[i+1] = 1;
        e_mit[i+1] = beats;
        beats++;
        lend = i;
      end
    end
    for (int i = 2; i <= lend + 1; i++) e_mode[i] = 1;
    nprod = NMAP * NPSUM;
    r0    = lend + 2;
    for (int i = 0; i < nprod; i++) begin
      c         = r0 + i;
      e_mode[c] = 2;
      e_reg[c]  = 1;
      e_mit[c]  = i % NMAP;
      e_pit[c]  = i / NMAP;
      e_rac[c]  = ((i % NMAP) != 0);
      e_pen[c + PIPE_LAT] = 1;
    end
    for (int i = 0; i < PIPE_LAT; i++) e_mode[r0 + nprod + i] = 2;
    a0 = r0 + nprod + PIPE_LAT;
    for (int j = 0; j < NPSUM; j++) begin
      e_mode[a0 + j]     = 3;
      e_pit[a0 + j]      = j;
      e_ov[a0 + j + 1]   = 1;
      e_oidx[a0 + j + 1] = j;
    end
    d_cyc = a0 + NPSUM;
    e_done[d_cyc] = 1;
    for (int i = 2; i <= d_cyc; i++) e_busy[i] = 1;
  endtask

  task automatic do_abort();
    #1 clr_ = 1'b1;
    #1;
    chk("async_clear", int'(all_outs), 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("held_clear", int'(all_outs), 0);
    clr_     = 1'b0;
    prev_cfg = 4'd0;
    for (int i = 0; i < 80; i++) begin
      @(posedge CLK);
      #1;
      cur_cyc  = i;
      start    = 1'b0;
      in_valid = 1'($urandom);
      @(negedge CLK);
      chk("abort_no_done", int'(done), 0);
      chk("abort_mode", int'(mode), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_map_en", int'(map_en), 0);
    end
  endtask

  task automatic run_task(input int kind, input logic [3:0] cfg, input bit abort);
    int d, r0, abort_at;
    build_model(kind, d, r0);
    abort_at = r0 + NMAP + 5;  // issue cycle with p=1, k=5
    for (int c = 0; c <= d + 1; c++) begin
      @(posedge CLK);
      #1;
      cur_cyc   = c;
      start     = (c == 0) || (c >= 1 && c < d && $urandom_range(0, 15) == 0);
      in_valid  = vld[c];
      shift_cfg = (c == 0) ? cfg : 4'($urandom);
      @(negedge CLK);
      chk("in_ready", int'(in_ready), int'(e_rdy[c]));
      chk("mode", int'(mode), e_mode[c]);
      chk("map_en", int'(map_en), int'(e_men[c]));
      chk("fil_en", int'(fil_en), int'(e_men[c]));
      chk("regs_en", int'(regs_en), int'(e_reg[c]));
      chk("p_en_delay", int'(p_en_delay), int'(e_pen[c]));
      chk("out_valid", int'(out_valid), int'(e_ov[c]));
      chk("done", int'(done), int'(e_done[c]));
      chk("busy", int'(busy), int'(e_busy[c]));
      chk("mult_bits", int'(mult_bits), (c == 0) ? int'(prev_cfg) : int'(cfg));
      chk("map_iter_bound", int'(map_iterator <= 4'(NMAP - 1)), 1);
      chk("psum_iter_bound", int'(psum_iterator <= 4'(NPSUM - 1)), 1);
      if (e_men[c] || e_reg[c]) begin
        chk("map_iter", int'(map_iterator), e_mit[c]);
        chk("fil_iter", int'(filter_iterator), e_mit[c]);
      end
      if (e_reg[c] || e_mode[c] == 3) chk("psum_iter", int'(psum_iterator), e_pit[c]);
      if (e_reg[c]) chk("rst_accm", int'(rst_accm), int'(e_rac[c]));
      if (e_ov[c]) chk("out_idx", int'(out_idx), e_oidx[c]);
      if (abort && c == abort_at) begin
        do_abort();
        return;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    prev_cfg = cfg;
  endtask

  initial begin
    clr_      = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    shift_cfg = 4'd0;
    n_total   = 0;
    n_bad     = 0;
    cur_cyc   = 0;
    prev_cfg  = 4'd0;
    #2;
    chk("reset_outs", int'(all_outs), 0);
    #6 clr_ = 1'b0;
    repeat (2) @(posedge CLK);
    run_task(0, 4'd3, 1'b0);   // nominal, no stalls
    run_task(1, 4'd9, 1'b0);   // alternating stalls
    for (int t = 0; t < 6; t++) run_task(2, 4'($urandom), 1'b0);
    run_task(0, 4'd5, 1'b1);   // reset in the middle of MULT
    run_task(0, 4'd3, 1'b0);   // fresh task after the abort
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
